// File: rtl/oven_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oven_pkg
//  Description : Shared types and constants for the oven cook timer and the
//                seven-segment decoder. It holds the cook-timer state encoding,
//                the time-storage width, and the active-low segment patterns.
//                Segment bit order is {g,f,e,d,c,b,a}, and a 0 lights the
//                segment.
//  Revision    : 1.0 - initial release
// ============================================================================
package oven_pkg;

    // Cook time is held as binary seconds. 13 bits covers 99:59 (5999 s).
    localparam int SEC_W = 13;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREHEAT = 2'd1,
        ST_RUN     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage : oven_pkg
`default_nettype wire

// File: rtl/oven_cook_timer_if.sv
`default_nettype none
// ============================================================================
//  Module      : oven_cook_timer_if
//  Description : Groups the user controls, the preheat flag and the display
//                and status outputs of the cook timer.
//                  master : drives the controls and observes the outputs
//                           (board glue or testbench)
//                  slave  : the cook timer itself
//                Ports:
//                  button1, button2 : active-low up/down buttons
//                  toggle_oven      : 1 = oven on
//                  toggle_set       : 0 = set mode
//                  temp_reached     : preheat complete
//                  hex3..hex0       : active-low 7-seg digits, mm:ss
//                  running, cook_done, alarm : status outputs
//  Revision    : 1.0 - initial release
// ============================================================================
interface oven_cook_timer_if;
    logic       button1;
    logic       button2;
    logic       toggle_oven;
    logic       toggle_set;
    logic       temp_reached;
    logic [6:0] hex3;
    logic [6:0] hex2;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic       running;
    logic       cook_done;
    logic       alarm;

    modport master (
        output button1, button2, toggle_oven, toggle_set, temp_reached,
        input  hex3, hex2, hex1, hex0, running, cook_done, alarm
    );

    modport slave (
        input  button1, button2, toggle_oven, toggle_set, temp_reached,
        output hex3, hex2, hex1, hex0, running, cook_done, alarm
    );
endinterface : oven_cook_timer_if
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_decode
//  Description : Converts a BCD digit to an active-low seven-segment pattern.
//                Codes above 9 show a blank digit. The temperature controller
//                shares this decoder.
//                Ports:
//                  i_digit [3:0] : BCD digit
//                  o_seg   [6:0] : active-low segments {g,f,e,d,c,b,a}
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_decode
    import oven_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_digit)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule : seg7_decode
`default_nettype wire

// File: rtl/oven_cook_timer.sv
`default_nettype none
// ============================================================================
//  Module      : oven_cook_timer
//  Description : Cook timer stage placed after the oven temperature
//                controller. The user sets a cook time in mm:ss with two
//                active-low buttons. Countdown starts once the oven is on and
//                preheat is complete. When the count reaches zero, a blinking
//                done alarm is raised.
//                Ports:
//                  clk   : system clock
//                  rst_n : asynchronous active-low reset
//                  bus   : controls / display / status (oven_cook_timer_if)
//  Revision    : 1.0 - initial release
// ============================================================================
module oven_cook_timer
    import oven_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int REPEAT_DIV  = 10_000_000,
    parameter int STEP_SEC    = 30,
    parameter int DEFAULT_SEC = 600,
    parameter int MAX_SEC     = 5999
) (
    input  logic             clk,
    input  logic             rst_n,
    oven_cook_timer_if.slave bus
);

    localparam int c_TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_RPT_W  = (REPEAT_DIV > 1) ? $clog2(REPEAT_DIV) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic [c_RPT_W-1:0]  c_RPT_LAST  = c_RPT_W'(REPEAT_DIV - 1);

    localparam logic [SEC_W-1:0] c_STEP    = SEC_W'(STEP_SEC);
    localparam logic [SEC_W-1:0] c_MAX     = SEC_W'(MAX_SEC);
    localparam logic [SEC_W-1:0] c_INC_LIM = SEC_W'(MAX_SEC - STEP_SEC);
    localparam logic [SEC_W-1:0] c_DEFAULT = SEC_W'(DEFAULT_SEC);

    // Synchroniser bit order: {temp_reached, toggle_set, toggle_oven, button2, button1}.
    // The buttons reset to the released (high) level so that no false
    // press is seen when reset is released.
    localparam logic [4:0] c_SYNC_RST = 5'b00011;

    logic [4:0]         w_sync_in;
    logic [4:0]         r_sync1;
    logic [4:0]         r_sync2;
    logic               w_b1_s;
    logic               w_b2_s;
    logic               w_oven_s;
    logic               w_set_s;
    logic               w_temp_s;

    logic [1:0]         r_btn_prev;
    logic               w_b1_held;
    logic               w_b2_held;
    logic               w_any_held;
    logic               w_btn_fall;
    logic               w_btn_en;
    logic               w_rpt_hit;
    logic               w_step;
    logic [c_RPT_W-1:0] r_rpt_cnt;

    logic [SEC_W-1:0]   r_set_sec;
    logic [SEC_W-1:0]   w_set_nxt;
    logic [SEC_W-1:0]   r_remain_sec;

    logic [c_TICK_W-1:0] r_tick_cnt;
    logic                w_timing;
    logic                w_tick;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_alarm;

    logic [SEC_W-1:0]   w_disp_sec;
    logic [6:0]         w_disp_min;
    logic [5:0]         w_disp_s;
    logic [3:0]         w_digit [4];
    logic [6:0]         w_seg   [4];

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    assign w_sync_in = {bus.temp_reached, bus.toggle_set, bus.toggle_oven,
                        bus.button2, bus.button1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= c_SYNC_RST;
            r_sync2 <= c_SYNC_RST;
        end else begin
            r_sync1 <= w_sync_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_b1_s   = r_sync2[0];
    assign w_b2_s   = r_sync2[1];
    assign w_oven_s = r_sync2[2];
    assign w_set_s  = r_sync2[3];
    assign w_temp_s = r_sync2[4];

    // ------------------------------------------------------------------
    // Button step / auto-repeat
    // ------------------------------------------------------------------
    assign w_b1_held  = ~w_b1_s;
    assign w_b2_held  = ~w_b2_s;
    assign w_any_held = w_b1_held | w_b2_held;
    assign w_btn_fall = (r_btn_prev[0] & w_b1_held) | (r_btn_prev[1] & w_b2_held);
    assign w_btn_en   = (r_state == ST_IDLE) && !w_set_s;
    assign w_rpt_hit  = w_any_held && (r_rpt_cnt == c_RPT_LAST);
    assign w_step     = w_btn_en && (w_btn_fall || w_rpt_hit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_prev <= 2'b11;
            r_rpt_cnt  <= '0;
        end else begin
            r_btn_prev <= {w_b2_s, w_b1_s};
            // Each step restarts the repeat interval. Release or leaving
            // set mode also discards any partial interval.
            if (!w_btn_en || !w_any_held || w_btn_fall || w_rpt_hit)
                r_rpt_cnt <= '0;
            else
                r_rpt_cnt <= r_rpt_cnt + 1'b1;
        end
    end

    // When both buttons are held, button1 sets the direction.
    // Both directions saturate at their limits and do not wrap.
    always_comb begin
        w_set_nxt = r_set_sec;
        if (w_step) begin
            if (w_b1_held)
                w_set_nxt = (r_set_sec >= c_INC_LIM) ? c_MAX : r_set_sec + c_STEP;
            else
                w_set_nxt = (r_set_sec <= c_STEP) ? '0 : r_set_sec - c_STEP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_set_sec <= c_DEFAULT;
        else
            r_set_sec <= w_set_nxt;
    end

    // ------------------------------------------------------------------
    // Tick prescaler. It is held at zero outside RUN/DONE, so the first
    // decrement comes a full TICK_DIV cycles after RUN is entered.
    // ------------------------------------------------------------------
    assign w_timing = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign w_tick   = w_timing && (r_tick_cnt == c_TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tick_cnt <= '0;
        else if (!w_timing || w_tick)
            r_tick_cnt <= '0;
        else
            r_tick_cnt <= r_tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // Cook FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // IDLE checks the next set time rather than the current one. This stops
    // a same-cycle decrement to zero from starting a zero-length cook.
    always_comb begin
        w_state_nxt = r_state;
        if (!w_oven_s) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_set_nxt != '0) w_state_nxt = ST_PREHEAT;
                ST_PREHEAT: if (w_temp_s) w_state_nxt = ST_RUN;
                ST_RUN:     if (w_tick && (r_remain_sec == SEC_W'(1))) w_state_nxt = ST_DONE;
                ST_DONE:    w_state_nxt = ST_DONE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Turning the oven off takes priority over a tick in the same cycle.
    // The remaining time reloads from the set time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remain_sec <= c_DEFAULT;
            r_alarm      <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || !w_oven_s)
                r_remain_sec <= w_set_nxt;
            else if ((r_state == ST_RUN) && w_tick)
                r_remain_sec <= r_remain_sec - 1'b1;

            if (!w_oven_s)
                r_alarm <= 1'b0;
            else if ((r_state == ST_RUN) && (w_state_nxt == ST_DONE))
                r_alarm <= 1'b1;
            else if ((r_state == ST_DONE) && w_tick)
                r_alarm <= ~r_alarm;
            else if (r_state != ST_DONE)
                r_alarm <= 1'b0;
        end
    end

    assign bus.running   = (r_state == ST_RUN);
    assign bus.cook_done = (r_state == ST_DONE);
    assign bus.alarm     = r_alarm;

    // ------------------------------------------------------------------
    // Display: select the source, split it into mm:ss, then decode
    // ------------------------------------------------------------------
    always_comb begin
        w_disp_sec = r_remain_sec;
        if (r_state == ST_IDLE)
            w_disp_sec = r_set_sec;
        else if (r_state == ST_DONE)
            w_disp_sec = '0;
    end

    assign w_disp_min = 7'(w_disp_sec / SEC_W'(60));
    assign w_disp_s   = 6'(w_disp_sec % SEC_W'(60));
    assign w_digit[3] = 4'(w_disp_min / 7'd10);
    assign w_digit[2] = 4'(w_disp_min % 7'd10);
    assign w_digit[1] = 4'(w_disp_s / 6'd10);
    assign w_digit[0] = 4'(w_disp_s % 6'd10);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            seg7_decode u_dec (
                .i_digit (w_digit[gi]),
                .o_seg   (w_seg[gi])
            );
        end
    endgenerate

    assign bus.hex3 = w_seg[3];
    assign bus.hex2 = w_seg[2];
    assign bus.hex1 = w_seg[1];
    assign bus.hex0 = w_seg[0];

endmodule : oven_cook_timer
`default_nettype wire
